// File: rtl/exec_pkg.sv
// Shared types and constants for the LEGv8 multi-cycle execute sequencer.
package exec_pkg;

    localparam int unsigned OPC_W = 11;
    localparam int unsigned ALU_W = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        ERROR  = 3'd6
    } state_e;

    typedef enum logic [3:0] {
        NONE  = 4'd0,
        R_ADD = 4'd1,
        R_SUB = 4'd2,
        R_AND = 4'd3,
        R_ORR = 4'd4,
        LDUR  = 4'd5,
        STUR  = 4'd6,
        CBZ   = 4'd7,
        B     = 4'd8
    } op_class_e;

    localparam logic [OPC_W-1:0] OP_R_ADD = 11'b10001011000;
    localparam logic [OPC_W-1:0] OP_R_SUB = 11'b11001011000;
    localparam logic [OPC_W-1:0] OP_R_AND = 11'b10001010000;
    localparam logic [OPC_W-1:0] OP_R_ORR = 11'b10101010000;
    localparam logic [OPC_W-1:0] OP_LDUR  = 11'b11111000010;
    localparam logic [OPC_W-1:0] OP_STUR  = 11'b11111000000;
    localparam logic [7:0]       OP_CBZ_PFX = 8'b10110100;
    localparam logic [5:0]       OP_B_PFX   = 6'b000101;

    localparam logic [ALU_W-1:0] ALU_AND   = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_OR    = 4'b0001;
    localparam logic [ALU_W-1:0] ALU_ADD   = 4'b0010;
    localparam logic [ALU_W-1:0] ALU_SUB   = 4'b0110;
    localparam logic [ALU_W-1:0] ALU_PASSB = 4'b0111;

    // ALU op for the EXEC/MEM/WB phases; loads and stores use ADD for address.
    function automatic logic [ALU_W-1:0] alu_op_for(input op_class_e cls);
        case (cls)
            R_SUB:   return ALU_SUB;
            R_AND:   return ALU_AND;
            R_ORR:   return ALU_OR;
            CBZ:     return ALU_PASSB;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode[31:21] -> instruction class, with an illegal flag.
module opcode_decoder
    import exec_pkg::*;
(
    input  logic [OPC_W-1:0] opcode_i,
    output op_class_e        op_class_c_o,
    output logic             illegal_c_o
);

    always_comb begin
        op_class_c_o = NONE;
        illegal_c_o  = 1'b0;
        if      (opcode_i == OP_R_ADD)           op_class_c_o = R_ADD;
        else if (opcode_i == OP_R_SUB)           op_class_c_o = R_SUB;
        else if (opcode_i == OP_R_AND)           op_class_c_o = R_AND;
        else if (opcode_i == OP_R_ORR)           op_class_c_o = R_ORR;
        else if (opcode_i == OP_LDUR)            op_class_c_o = LDUR;
        else if (opcode_i == OP_STUR)            op_class_c_o = STUR;
        else if (opcode_i[10:3] == OP_CBZ_PFX)   op_class_c_o = CBZ;
        else if (opcode_i[10:5] == OP_B_PFX)     op_class_c_o = B;
        else                                     illegal_c_o  = 1'b1;
    end

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle LEGv8 control FSM: FETCH/DECODE/EXEC/MEM/WB with memory
// handshake stalls, stall timeout and illegal-opcode trap.
module exec_sequencer
    import exec_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [10:0]      opcode,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_src,
    output logic             ir_write,
    output logic             alu_src,
    output logic [3:0]       alu_operation,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             retire,
    output logic [CNT_W-1:0] instr_count,
    output logic             illegal,
    output logic             timeout
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    state_e            state_q, state_d;
    op_class_e         class_q, class_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              illegal_q, illegal_d;
    logic              timeout_q, timeout_d;

    op_class_e dec_class;
    logic      dec_illegal;

    opcode_decoder u_dec (
        .opcode_i     (opcode),
        .op_class_c_o (dec_class),
        .illegal_c_o  (dec_illegal)
    );

    // Next state and combinational control decode.
    always_comb begin
        state_d       = state_q;
        class_d       = class_q;
        wait_d        = wait_q;
        illegal_d     = illegal_q;
        timeout_d     = timeout_q;
        pc_write      = 1'b0;
        pc_src        = 1'b0;
        ir_write      = 1'b0;
        alu_src       = 1'b0;
        alu_operation = 4'b0000;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        retire        = 1'b0;

        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end else if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = ERROR;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            DECODE: begin
                if (dec_illegal) begin
                    illegal_d = 1'b1;
                    state_d   = ERROR;
                end else begin
                    class_d = dec_class;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                alu_operation = alu_op_for(class_q);
                case (class_q)
                    R_ADD, R_SUB, R_AND, R_ORR: state_d = WB;
                    LDUR, STUR: begin
                        alu_src = 1'b1;
                        state_d = MEM;
                    end
                    CBZ: begin
                        pc_src   = 1'b1;
                        pc_write = alu_zero;
                        retire   = 1'b1;
                        state_d  = FETCH;
                    end
                    B: begin
                        alu_operation = 4'b0000;
                        pc_src   = 1'b1;
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        state_d  = FETCH;
                    end
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = ERROR;
                    end
                endcase
            end
            MEM: begin
                alu_src       = 1'b1;
                alu_operation = ALU_ADD;
                mem_read      = (class_q == LDUR);
                mem_write     = (class_q != LDUR);
                if (mem_ready) begin
                    if (class_q == LDUR) begin
                        state_d = WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = FETCH;
                    end
                end else if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = ERROR;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            WB: begin
                alu_src       = (class_q == LDUR);
                alu_operation = alu_op_for(class_q);
                mem_to_reg    = (class_q == LDUR);
                reg_write     = 1'b1;
                retire        = 1'b1;
                state_d       = FETCH;
            end
            ERROR: state_d = ERROR;
            default: state_d = ERROR;
        endcase

        // Every state change starts a fresh stall window.
        if (state_d != state_q) begin
            wait_d = '0;
        end
        count_d = retire ? count_q + CNT_W'(1) : count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            class_q   <= NONE;
            wait_q    <= '0;
            count_q   <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            wait_q    <= wait_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    assign instr_count = count_q;
    assign illegal     = illegal_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed self-checking bench for exec_sequencer.
module tb_exec_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] opcode;
    logic        alu_zero, mem_ready;
    logic        pc_write, pc_src, ir_write, alu_src;
    logic [3:0]  alu_operation;
    logic        mem_read, mem_write, mem_to_reg, reg_write, retire;
    logic [31:0] instr_count;
    logic        illegal, timeout;
    logic [12:0] obs;

    int total = 0;
    int bad   = 0;

    exec_sequencer #(.MAX_WAIT(15), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .alu_zero(alu_zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src),
        .ir_write(ir_write), .alu_src(alu_src), .alu_operation(alu_operation),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .retire(retire), .instr_count(instr_count),
        .illegal(illegal), .timeout(timeout)
    );

    always #5 clk = ~clk;

    assign obs = {pc_write, pc_src, ir_write, alu_src, alu_operation,
                  mem_read, mem_write, mem_to_reg, reg_write, retire};

    localparam logic [12:0] V_ZERO   = 13'd0;
    localparam logic [12:0] V_FSTALL = 13'b0_0_0_0_0000_1_0_0_0_0;
    localparam logic [12:0] V_FRDY   = 13'b1_0_1_0_0000_1_0_0_0_0;

    function automatic logic [12:0] v(input logic pcw, input logic pcs, input logic irw,
                                      input logic asrc, input logic [3:0] op, input logic mr,
                                      input logic mw, input logic m2r, input logic rw,
                                      input logic ret);
        return {pcw, pcs, irw, asrc, op, mr, mw, m2r, rw, ret};
    endfunction

    task automatic go(input logic mr, input logic az);
        @(negedge clk);
        mem_ready = mr;
        alu_zero  = az;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; mem_ready = 1'b0; alu_zero = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b1; alu_zero = 1'b1; opcode = 11'b10001011000;
        #3;
        total++;
        if ({obs, instr_count, illegal, timeout} !== 47'd0) begin
            bad++;
            $display("FAIL reset_state: got obs=%b cnt=%0d ill=%b to=%b, want all 0",
                     obs, instr_count, illegal, timeout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (obs !== V_ZERO) begin
            bad++;
            $display("FAIL idle_outputs: got %b want %b", obs, V_ZERO);
        end
    endtask

    task automatic test_add();
        logic [12:0] exp [4];
        do_reset();
        opcode = 11'b10001011000;
        exp = '{V_FRDY, V_ZERO, v(0,0,0,0,4'b0010,0,0,0,0,0), v(0,0,0,0,4'b0010,0,0,0,1,1)};
        for (int i = 0; i < 4; i++) begin
            go(1'b1, 1'b0);
            total++;
            if (obs !== exp[i]) begin
                bad++;
                $display("FAIL add_cycle%0d: got %b want %b", i, obs, exp[i]);
            end
        end
        go(1'b1, 1'b0);
        total++;
        if (instr_count !== 32'd1 || obs !== V_FRDY) begin
            bad++;
            $display("FAIL add_count: got cnt=%0d obs=%b want cnt=1 obs=%b", instr_count, obs, V_FRDY);
        end
    endtask

    task automatic test_rtype_ops();
        logic [10:0] opc [3];
        logic [3:0]  op  [3];
        opc = '{11'b11001011000, 11'b10001010000, 11'b10101010000};
        op  = '{4'b0110, 4'b0000, 4'b0001};
        for (int k = 0; k < 3; k++) begin
            do_reset();
            opcode = opc[k];
            go(1'b1, 1'b0);
            go(1'b0, 1'b1);
            go(1'b0, 1'b1);
            total++;
            if (obs !== v(0,0,0,0,op[k],0,0,0,0,0)) begin
                bad++;
                $display("FAIL rtype%0d_exec: got %b want op=%b", k, obs, op[k]);
            end
            go(1'b0, 1'b0);
            total++;
            if (obs !== v(0,0,0,0,op[k],0,0,0,1,1)) begin
                bad++;
                $display("FAIL rtype%0d_wb: got %b want op=%b rw=1 ret=1", k, obs, op[k]);
            end
        end
    endtask

    task automatic test_ldur_stall();
        logic [12:0] exp [8];
        logic        mr  [8];
        logic [12:0] mem_v;
        do_reset();
        opcode = 11'b11111000010;
        mem_v = v(0,0,0,1,4'b0010,1,0,0,0,0);
        exp = '{V_FRDY, V_ZERO, v(0,0,0,1,4'b0010,0,0,0,0,0), mem_v, mem_v, mem_v, mem_v,
                v(0,0,0,1,4'b0010,0,0,1,1,1)};
        mr  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            go(mr[i], 1'b0);
            total++;
            if (obs !== exp[i]) begin
                bad++;
                $display("FAIL ldur_cycle%0d: got %b want %b", i, obs, exp[i]);
            end
        end
        go(1'b0, 1'b0);
        total++;
        if (instr_count !== 32'd1 || obs !== V_FSTALL) begin
            bad++;
            $display("FAIL ldur_count: got cnt=%0d obs=%b want cnt=1 obs=%b", instr_count, obs, V_FSTALL);
        end
    endtask

    task automatic test_branches();
        do_reset();
        opcode = 11'b10110100101;
        go(1'b1, 1'b0); go(1'b1, 1'b1); go(1'b1, 1'b1);
        total++;
        if (obs !== v(1,1,0,0,4'b0111,0,0,0,0,1)) begin
            bad++;
            $display("FAIL cbz_taken: got %b want %b", obs, v(1,1,0,0,4'b0111,0,0,0,0,1));
        end
        opcode = 11'b10110100000;
        go(1'b1, 1'b0); go(1'b1, 1'b0); go(1'b1, 1'b0);
        total++;
        if (obs !== v(0,1,0,0,4'b0111,0,0,0,0,1)) begin
            bad++;
            $display("FAIL cbz_not_taken: got %b want %b", obs, v(0,1,0,0,4'b0111,0,0,0,0,1));
        end
        opcode = 11'b00010111111;
        go(1'b1, 1'b0);
        total++;
        if (instr_count !== 32'd2) begin
            bad++;
            $display("FAIL cbz_count: got %0d want 2", instr_count);
        end
        go(1'b1, 1'b0); go(1'b1, 1'b0);
        total++;
        if (obs !== v(1,1,0,0,4'b0000,0,0,0,0,1)) begin
            bad++;
            $display("FAIL b_exec: got %b want %b", obs, v(1,1,0,0,4'b0000,0,0,0,0,1));
        end
        go(1'b0, 1'b0);
        total++;
        if (instr_count !== 32'd3) begin
            bad++;
            $display("FAIL b_count: got %0d want 3", instr_count);
        end
    endtask

    task automatic test_stur();
        do_reset();
        opcode = 11'b11111000000;
        go(1'b1, 1'b0); go(1'b1, 1'b0); go(1'b1, 1'b0);
        go(1'b1, 1'b0);
        total++;
        if (obs !== v(0,0,0,1,4'b0010,0,1,0,0,1)) begin
            bad++;
            $display("FAIL stur_mem: got %b want %b", obs, v(0,0,0,1,4'b0010,0,1,0,0,1));
        end
        go(1'b0, 1'b0);
        total++;
        if (instr_count !== 32'd1 || obs !== V_FSTALL) begin
            bad++;
            $display("FAIL stur_count: got cnt=%0d obs=%b want cnt=1 obs=%b", instr_count, obs, V_FSTALL);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        opcode = 11'b11111111111;
        go(1'b1, 1'b0);
        go(1'b1, 1'b0);
        total++;
        if ({obs, illegal} !== 14'd0) begin
            bad++;
            $display("FAIL illegal_decode: got obs=%b ill=%b want 0/0", obs, illegal);
        end
        for (int i = 0; i < 20; i++) begin
            go(i[0], 1'b1);
            total++;
            if ({obs, illegal, timeout} !== {V_ZERO, 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL illegal_error%0d: got obs=%b ill=%b to=%b want 0/1/0", i, obs, illegal, timeout);
            end
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (illegal !== 1'b0) begin
            bad++;
            $display("FAIL illegal_clear: got %b want 0", illegal);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        opcode = 11'b10001011000;
        for (int i = 0; i < 15; i++) begin
            go(1'b0, 1'b0);
            total++;
            if ({obs, timeout} !== {V_FSTALL, 1'b0}) begin
                bad++;
                $display("FAIL timeout_stall%0d: got obs=%b to=%b want %b/0", i, obs, timeout, V_FSTALL);
            end
        end
        go(1'b1, 1'b0);
        total++;
        if ({obs, timeout} !== {V_ZERO, 1'b1}) begin
            bad++;
            $display("FAIL timeout_trap: got obs=%b to=%b want 0/1", obs, timeout);
        end
        do_reset();
        for (int i = 0; i < 14; i++) go(1'b0, 1'b0);
        go(1'b1, 1'b0);
        total++;
        if (obs !== V_FRDY) begin
            bad++;
            $display("FAIL late_ready_fetch: got %b want %b", obs, V_FRDY);
        end
        go(1'b0, 1'b0);
        go(1'b0, 1'b0);
        total++;
        if ({obs, timeout} !== {v(0,0,0,0,4'b0010,0,0,0,0,0), 1'b0}) begin
            bad++;
            $display("FAIL late_ready_exec: got obs=%b to=%b want add exec, to=0", obs, timeout);
        end
    endtask

    task automatic test_reset_mid_stur();
        do_reset();
        opcode = 11'b11111000000;
        go(1'b1, 1'b0); go(1'b1, 1'b0); go(1'b1, 1'b0);
        go(1'b0, 1'b0);
        total++;
        if (obs !== v(0,0,0,1,4'b0010,0,1,0,0,0)) begin
            bad++;
            $display("FAIL stur_stall: got %b want %b", obs, v(0,0,0,1,4'b0010,0,1,0,0,0));
        end
        rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        total++;
        if ({obs, instr_count} !== 45'd0) begin
            bad++;
            $display("FAIL reset_abort: got obs=%b cnt=%0d want 0/0", obs, instr_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_rtype_ops();
        test_ldur_stall();
        test_branches();
        test_stur();
        test_illegal();
        test_timeout();
        test_reset_mid_stur();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
